// File: rtl/rle_stream_ctrl.sv
// Run-length sequencer for DCT coefficient blocks: folds equal consecutive
// coefficients into (value, count) pairs and closes every block with a last=1 pair.
module rle_stream_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 3,
    parameter int BLOCK_LEN = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [CNT_W-1:0] out_count,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      blk_done,
    output logic             busy
);

    localparam int K_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] MAX_RUN = '1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   run_val_q, run_val_d;
    logic        [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic        [K_W-1:0]     k_q, k_d;
    logic signed [WIDTH-1:0]   slot_val_q, slot_val_d;
    logic        [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic                      slot_last_q, slot_last_d;
    logic                      slot_vld_q, slot_vld_d;
    logic        [15:0]        blk_done_q, blk_done_d;

    logic slot_free;
    logic accept;

    // A run is saturated once its counter reaches the largest representable count.
    function automatic logic run_full(input logic [CNT_W-1:0] cnt);
        return cnt == MAX_RUN;
    endfunction

    assign slot_free = !slot_vld_q || out_ready;
    assign in_ready  = (state_q == RUN) && slot_free;
    assign accept    = in_valid && in_ready;

    assign out_value = slot_val_q;
    assign out_count = slot_cnt_q;
    assign out_last  = slot_last_q;
    assign out_valid = slot_vld_q;
    assign blk_done  = blk_done_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        run_val_d   = run_val_q;
        run_cnt_d   = run_cnt_q;
        k_d         = k_q;
        slot_val_d  = slot_val_q;
        slot_cnt_d  = slot_cnt_q;
        slot_last_d = slot_last_q;
        slot_vld_d  = slot_vld_q;
        blk_done_d  = blk_done_q;

        if (slot_vld_q && out_ready) begin
            slot_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (k_q == '0) begin
                        run_val_d = $signed(in_data);
                        run_cnt_d = CNT_W'(1);
                    end else if ($signed(in_data) == run_val_q && !run_full(run_cnt_q)) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end else begin
                        slot_val_d  = run_val_q;
                        slot_cnt_d  = run_cnt_q;
                        slot_last_d = 1'b0;
                        slot_vld_d  = 1'b1;
                        run_val_d   = $signed(in_data);
                        run_cnt_d   = CNT_W'(1);
                    end
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = FLUSH;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Once the closing pair sits in the slot, wait for it to leave.
                if (slot_vld_q && slot_last_q) begin
                    if (out_ready) begin
                        blk_done_d = blk_done_q + 16'd1;
                        state_d    = en ? RUN : IDLE;
                    end
                end else if (slot_free) begin
                    slot_val_d  = run_val_q;
                    slot_cnt_d  = run_cnt_q;
                    slot_last_d = 1'b1;
                    slot_vld_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            run_val_q   <= '0;
            run_cnt_q   <= '0;
            k_q         <= '0;
            slot_val_q  <= '0;
            slot_cnt_q  <= '0;
            slot_last_q <= 1'b0;
            slot_vld_q  <= 1'b0;
            blk_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            k_q         <= k_d;
            slot_val_q  <= slot_val_d;
            slot_cnt_q  <= slot_cnt_d;
            slot_last_q <= slot_last_d;
            slot_vld_q  <= slot_vld_d;
            blk_done_q  <= blk_done_d;
        end
    end

endmodule
